// File: rtl/pow_seq.sv
// pow_seq: sequential y = x^e using one shared external multiplier over a start/busy handshake.
// Ports: clk_i/rst_i (sync active-high reset); x_bi, exp_bi, start_i request in;
//        mul_a, mul_b, mul_start_i drive the multiplier; mul_busy_o, mul_y_bo come back from it;
//        busy_o, done_o, ovf_o, y_bo report status and result to the controller.
module pow_seq #(
   parameter int W     = 8,
   parameter int RW    = 16,
   parameter int EXP_W = 4,
   parameter int SAT   = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [W-1:0]      x_bi,
   input  logic [EXP_W-1:0]  exp_bi,
   input  logic              start_i,
   output logic [RW-1:0]     mul_a,
   output logic [W-1:0]      mul_b,
   output logic              mul_start_i,
   input  logic              mul_busy_o,
   input  logic [RW+W-1:0]   mul_y_bo,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o,
   output logic [RW-1:0]     y_bo
);
   typedef enum logic [2:0] {IDLE, START, WAIT1, WAIT2, DONE} state_t;
   state_t           state_q;
   logic [W-1:0]     x_q;
   logic [EXP_W-1:0] cnt_q;
   logic [RW-1:0]    acc_q, acc_d, mul_a_q, y_q;
   logic [W-1:0]     mul_b_q;
   logic             ovf_q, ovf_d, mul_start_q, ovf_o_q, done_q;
   assign acc_d = mul_y_bo[RW-1:0];
   // Overflow is sticky: any nonzero bit above the accumulator width in any step.
   assign ovf_d = ovf_q | (|mul_y_bo[RW+W-1:RW]);
   // Result and done are registered on entry to DONE so done_o coincides with the new y_bo.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         x_q         <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_start_q <= 1'b0;
         y_q         <= '0;
         ovf_o_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               x_q   <= x_bi;
               cnt_q <= exp_bi;
               acc_q <= RW'(1);
               ovf_q <= 1'b0;
               if (exp_bi == '0) begin
                  state_q <= DONE;
                  y_q     <= RW'(1);
                  ovf_o_q <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= START;
               end
            end
            START: begin
               mul_a_q     <= acc_q;
               mul_b_q     <= x_q;
               mul_start_q <= 1'b1;
               state_q     <= WAIT1;
            end
            WAIT1: begin
               mul_start_q <= 1'b0;
               state_q     <= WAIT2;
            end
            WAIT2: if (!mul_busy_o) begin
               acc_q <= acc_d;
               ovf_q <= ovf_d;
               cnt_q <= cnt_q - EXP_W'(1);
               if (cnt_q == EXP_W'(1)) begin
                  state_q <= DONE;
                  y_q     <= (SAT != 0 && ovf_d) ? {RW{1'b1}} : acc_d;
                  ovf_o_q <= ovf_d;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= START;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign mul_start_i = mul_start_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign ovf_o       = ovf_o_q;
   assign y_bo        = y_q;
endmodule
